cache_ctrl: RTL and testbench

Two-way set-associative data cache with its controller. It sits between the CPU load/store stage and main memory. It holds valid, use (LRU) and tag state plus two 32-bit words per line in 16 sets, and serves hits combinationally. Misses and all stores are sequenced through a single-outstanding request/acknowledge memory port. Policy: write-through, no-write-allocate, read-allocate with LRU replacement.

---
 rtl/cache_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Hits are served combinationally; misses and stores go through a single-outstanding memory port.
module cache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int SET_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDR_WIDTH - SET_BITS - 3;

  typedef enum logic [1:0] {IDLE, REFILL0, REFILL1, WRITE} state_t;

  state_t                  state_r, state_nx;
  logic [SETS-1:0]         valid_r [2];
  logic [SETS-1:0]         use_r   [2];
  logic [TAG_BITS-1:0]     tag_r   [2][SETS];
  logic [DATA_WIDTH-1:0]   data_r  [2][SETS][2];
  logic [ADDR_WIDTH-4:0]   lat_line_r;
  logic                    victim_r;
  logic                    done_r, done_nx;
  logic                    mem_req_r, mem_req_nx;
  logic                    mem_we_r, mem_we_nx;
  logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_nx;
  logic [DATA_WIDTH-1:0]   mem_wdata_r, mem_wdata_nx;

  logic [SET_BITS-1:0]     set_s, lat_set_s;
  logic [TAG_BITS-1:0]     tag_s, lat_tag_s;
  logic                    off_s;
  logic                    hit0_s, hit1_s, hit_s, hit_way_s, victim_s;
  logic                    accept_s, load_hit_s, load_miss_s, store_s, store_hit_s;
  logic                    fill0_s, fill1_s;
  logic                    unused_s;

  assign set_s     = cpu_addr[SET_BITS+2:3];
  assign tag_s     = cpu_addr[ADDR_WIDTH-1:SET_BITS+3];
  assign off_s     = cpu_addr[2];
  assign lat_set_s = lat_line_r[SET_BITS-1:0];
  assign lat_tag_s = lat_line_r[ADDR_WIDTH-4:SET_BITS];
  assign unused_s  = ^cpu_addr[1:0];

  assign hit0_s    = valid_r[0][set_s] && (tag_r[0][set_s] == tag_s);
  assign hit1_s    = valid_r[1][set_s] && (tag_r[1][set_s] == tag_s);
  assign hit_s     = hit0_s | hit1_s;
  assign hit_way_s = hit1_s;

  // The held store gets its single completion cycle after the write ack and is not re-latched.
  assign accept_s    = (state_r == IDLE) && cpu_req && !(done_r && cpu_we);
  assign load_hit_s  = accept_s && !cpu_we && hit_s;
  assign load_miss_s = accept_s && !cpu_we && !hit_s;
  assign store_s     = accept_s && cpu_we;
  assign store_hit_s = store_s && hit_s;
  assign fill0_s     = (state_r == REFILL0) && mem_ack;
  assign fill1_s     = (state_r == REFILL1) && mem_ack;

  assign cpu_rdata = data_r[hit_way_s][set_s][off_s];
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

  // Victim selection: first invalid way, else the way whose use bit is clear.
  always_comb begin
    victim_s = 1'b0;
    if (!valid_r[0][set_s]) begin
      victim_s = 1'b0;
    end else if (!valid_r[1][set_s]) begin
      victim_s = 1'b1;
    end else if (!use_r[0][set_s]) begin
      victim_s = 1'b0;
    end else begin
      victim_s = 1'b1;
    end
  end

  // CPU stall: only an IDLE hit or an idle cycle completes without waiting.
  always_comb begin
    cpu_stall = 1'b1;
    if (state_r == IDLE) begin
      cpu_stall = load_miss_s | store_s;
    end else begin
      cpu_stall = 1'b1;
    end
  end

  // Next-state and next memory-port register values.
  always_comb begin
    state_nx     = state_r;
    done_nx      = 1'b0;
    mem_req_nx   = mem_req_r;
    mem_we_nx    = mem_we_r;
    mem_addr_nx  = mem_addr_r;
    mem_wdata_nx = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (load_miss_s) begin
          state_nx    = REFILL0;
          mem_req_nx  = 1'b1;
          mem_we_nx   = 1'b0;
          mem_addr_nx = {tag_s, set_s, 1'b0, 2'b00};
        end else if (store_s) begin
          state_nx     = WRITE;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b1;
          mem_addr_nx  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_nx = cpu_wdata;
        end else begin
          state_nx = IDLE;
        end
      end
      REFILL0: begin
        if (mem_ack) begin
          state_nx    = REFILL1;
          mem_addr_nx = {lat_tag_s, lat_set_s, 1'b1, 2'b00};
        end else begin
          state_nx = REFILL0;
        end
      end
      REFILL1: begin
        if (mem_ack) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
        end else begin
          state_nx = REFILL1;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          mem_we_nx  = 1'b0;
          done_nx    = 1'b1;
        end else begin
          state_nx = WRITE;
        end
      end
      default: begin
        state_nx   = IDLE;
        mem_req_nx = 1'b0;
        mem_we_nx  = 1'b0;
      end
    endcase
  end

  // Control state, valid/use bits and memory-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      valid_r[0]  <= {SETS{1'b0}};
      valid_r[1]  <= {SETS{1'b0}};
      use_r[0]    <= {SETS{1'b0}};
      use_r[1]    <= {SETS{1'b0}};
      lat_line_r  <= {(ADDR_WIDTH-3){1'b0}};
      victim_r    <= 1'b0;
      done_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nx;
      done_r      <= done_nx;
      mem_req_r   <= mem_req_nx;
      mem_we_r    <= mem_we_nx;
      mem_addr_r  <= mem_addr_nx;
      mem_wdata_r <= mem_wdata_nx;
      if (load_miss_s) begin
        lat_line_r <= cpu_addr[ADDR_WIDTH-1:3];
        victim_r   <= victim_s;
      end
      if (load_hit_s || store_hit_s) begin
        use_r[hit_way_s][set_s]  <= 1'b1;
        use_r[~hit_way_s][set_s] <= 1'b0;
      end else if (fill1_s) begin
        valid_r[victim_r][lat_set_s] <= 1'b1;
        use_r[victim_r][lat_set_s]   <= 1'b1;
        use_r[~victim_r][lat_set_s]  <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (store_hit_s) begin
      data_r[hit_way_s][set_s][off_s] <= cpu_wdata;
    end else if (fill0_s) begin
      data_r[victim_r][lat_set_s][0] <= mem_rdata;
    end else if (fill1_s) begin
      data_r[victim_r][lat_set_s][1] <= mem_rdata;
      tag_r[victim_r][lat_set_s]     <= lat_tag_s;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: memory responder with programmable ack latency
// and a line-level cache model (MRU pointer per set, shadow memory) for expectations.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- memory responder ----------------
  int          ack_lat = 0;
  int          wait_cnt = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          hs_errors = 0;
  logic        beat_open = 1'b0;
  logic [31:0] beat_addr, beat_wdata;
  logic        beat_we;
  logic        expect_cont = 1'b0;
  logic        expect_low = 1'b0;
  logic [32:0] mem_log [$];
  logic [31:0] mem_arr [logic [31:0]];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  initial begin
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0; wait_cnt = 0; beat_open = 1'b0;
        expect_cont = 1'b0; expect_low = 1'b0;
      end else begin
        if (expect_cont && !(mem_req && mem_addr[2] && !mem_we)) hs_errors++;
        if (expect_low && mem_req) hs_errors++;
        expect_cont = 1'b0; expect_low = 1'b0;
        if (mem_ack) begin
          mem_ack = 1'b0; wait_cnt = 0; beat_open = 1'b0;
        end
        if (mem_req) begin
          if (!beat_open) begin
            beat_open = 1'b1; beat_addr = mem_addr; beat_we = mem_we; beat_wdata = mem_wdata;
          end else if (mem_addr !== beat_addr || mem_we !== beat_we ||
                       (beat_we && mem_wdata !== beat_wdata)) begin
            hs_errors++;
          end
          if (wait_cnt >= ack_lat) begin
            mem_ack = 1'b1;
            mem_log.push_back({mem_we, mem_addr});
            if (mem_we) begin
              mem_arr[mem_addr] = mem_wdata;
              n_writes++;
              expect_low = 1'b1;
            end else begin
              mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : mem_init(mem_addr);
              n_reads++;
              if (mem_addr[2]) expect_low = 1'b1;
              else expect_cont = 1'b1;
            end
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic        ref_valid [2][16];
  logic [24:0] ref_tag   [2][16];
  int          ref_mru   [16];
  logic [31:0] ref_mem   [logic [31:0]];

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      ref_valid[0][s] = 1'b0; ref_valid[1][s] = 1'b0; ref_mru[s] = 1;
    end
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int lat, output int exp_stall, output logic [31:0] exp_data,
                              output int exp_reads, output int exp_writes);
    int s, hit, vic;
    logic [31:0] w;
    s = int'(addr[6:3]);
    w = {addr[31:2], 2'b00};
    hit = -1;
    for (int k = 0; k < 2; k++)
      if (ref_valid[k][s] && ref_tag[k][s] == addr[31:7]) hit = k;
    exp_reads = 0; exp_writes = 0; exp_stall = 0;
    if (we) begin
      ref_mem[w] = wdata;
      exp_writes = 1;
      exp_stall = 1 + (lat + 1);
      if (hit >= 0) ref_mru[s] = hit;
    end else if (hit >= 0) begin
      ref_mru[s] = hit;
    end else begin
      if (!ref_valid[0][s]) vic = 0;
      else if (!ref_valid[1][s]) vic = 1;
      else vic = 1 - ref_mru[s];
      ref_valid[vic][s] = 1'b1;
      ref_tag[vic][s] = addr[31:7];
      ref_mru[s] = vic;
      exp_reads = 2;
      exp_stall = 1 + 2 * (lat + 1);
    end
    exp_data = ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
  endtask

  // ---------------- CPU driver ----------------
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int stalls, output logic [31:0] rdata, output logic timeout);
    logic done;
    stalls = 0; rdata = 32'h0; done = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        rdata = cpu_rdata; done = 1'b1;
        break;
      end
      stalls++;
    end
    timeout = !done;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_cpu_stall: got %b expected 0", cpu_stall); end
    rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_directed();
    logic        t_we   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_addr [11] = '{32'h84, 32'h80, 32'h80, 32'h880, 32'h1080, 32'h880, 32'h80,
                                 32'h84, 32'h84, 32'h2004, 32'h2004};
    logic [31:0] t_wd   [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'hDEAD_BEEF, 32'h0, 32'h1234_5678, 32'h0};
    int          t_st   [11] = '{3, 0, 0, 3, 3, 0, 3, 2, 0, 2, 3};
    int          t_rd   [11] = '{2, 0, 0, 2, 2, 0, 2, 0, 0, 0, 2};
    int          t_wr   [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    int stalls, es, er, ew, r0, w0;
    logic [31:0] rd, ed, line;
    logic to;
    ack_lat = 0;
    for (int i = 0; i < 11; i++) begin
      model_access(t_we[i], t_addr[i], t_wd[i], 0, es, ed, er, ew);
      mem_log.delete();
      r0 = n_reads; w0 = n_writes;
      do_access(t_we[i], t_addr[i], t_wd[i], stalls, rd, to);
      checks++; if (to || stalls != t_st[i]) begin failures++; $display("FAIL dir_stall[%0d]: got %0d expected %0d", i, stalls, t_st[i]); end
      checks++; if (n_reads - r0 != t_rd[i]) begin failures++; $display("FAIL dir_reads[%0d]: got %0d expected %0d", i, n_reads - r0, t_rd[i]); end
      checks++; if (n_writes - w0 != t_wr[i]) begin failures++; $display("FAIL dir_writes[%0d]: got %0d expected %0d", i, n_writes - w0, t_wr[i]); end
      if (!t_we[i]) begin
        checks++; if (rd !== ed) begin failures++; $display("FAIL dir_rdata[%0d]: got %h expected %h", i, rd, ed); end
      end
      line = {t_addr[i][31:3], 3'b000};
      if (t_rd[i] == 2) begin
        checks++;
        if (mem_log.size() != 2 || mem_log[0] !== {1'b0, line} || mem_log[1] !== {1'b0, line | 32'h4}) begin
          failures++; $display("FAIL dir_refill_addr[%0d]: got %0d beats expected 2 beats at %h,%h", i, mem_log.size(), line, line | 32'h4);
        end
      end
      if (t_wr[i] == 1) begin
        checks++;
        if (mem_log.size() != 1 || mem_log[0] !== {1'b1, t_addr[i][31:2], 2'b00}) begin
          failures++; $display("FAIL dir_write_addr[%0d]: got %0d ops expected 1 write at %h", i, mem_log.size(), t_addr[i]);
        end
      end
    end
    checks++; if (ref_mem[32'h84] !== 32'hDEAD_BEEF || mem_arr[32'h84] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL dir_mem_84: got %h expected deadbeef", mem_arr[32'h84]);
    end
  endtask

  task automatic test_ack_delay();
    int stalls, es, er, ew, r0, h0;
    logic [31:0] rd, ed;
    logic to;
    ack_lat = 3;
    h0 = hs_errors;
    model_access(1'b0, 32'h5000_0110, 32'h0, 3, es, ed, er, ew);
    r0 = n_reads;
    do_access(1'b0, 32'h5000_0110, 32'h0, stalls, rd, to);
    checks++; if (to || stalls != 9) begin failures++; $display("FAIL delay_load_stall: got %0d expected 9", stalls); end
    checks++; if (rd !== ed) begin failures++; $display("FAIL delay_load_rdata: got %h expected %h", rd, ed); end
    checks++; if (n_reads - r0 != 2) begin failures++; $display("FAIL delay_load_reads: got %0d expected 2", n_reads - r0); end
    model_access(1'b1, 32'h5000_0114, 32'hCAFE_F00D, 3, es, ed, er, ew);
    do_access(1'b1, 32'h5000_0114, 32'hCAFE_F00D, stalls, rd, to);
    checks++; if (to || stalls != 5) begin failures++; $display("FAIL delay_store_stall: got %0d expected 5", stalls); end
    checks++; if (hs_errors != h0) begin failures++; $display("FAIL delay_handshake: got %0d errors expected 0", hs_errors - h0); end
  endtask

  task automatic test_drop_mid_miss();
    int stalls, es, er, ew, r0;
    logic [31:0] rd, ed;
    logic to, settled;
    ack_lat = 2;
    r0 = n_reads;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000_0040; cpu_wdata = 32'h0;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL drop_stall: got %b expected 1", cpu_stall); end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    settled = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!mem_req && n_reads - r0 == 2) begin settled = 1'b1; break; end
    end
    checks++; if (!settled) begin failures++; $display("FAIL drop_refill_done: got %0d reads expected 2", n_reads - r0); end
    model_access(1'b0, 32'h3000_0040, 32'h0, 2, es, ed, er, ew);
    do_access(1'b0, 32'h3000_0044, 32'h0, stalls, rd, to);
    model_access(1'b0, 32'h3000_0044, 32'h0, 2, es, ed, er, ew);
    checks++; if (to || stalls != 0) begin failures++; $display("FAIL drop_then_hit: got %0d stalls expected 0", stalls); end
    checks++; if (rd !== ed) begin failures++; $display("FAIL drop_then_rdata: got %h expected %h", rd, ed); end
  endtask

  task automatic test_reset_in_refill();
    int stalls, es, er, ew, r0;
    logic [31:0] rd, ed;
    logic to, seen;
    ack_lat = 3;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4000_0088; cpu_wdata = 32'h0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr[2]) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_refill_reach: got 0 expected 1"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_refill_mem_req: got %b expected 0", mem_req); end
    cpu_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    r0 = n_reads;
    model_access(1'b0, 32'h4000_0088, 32'h0, 3, es, ed, er, ew);
    do_access(1'b0, 32'h4000_0088, 32'h0, stalls, rd, to);
    checks++; if (to || stalls != 9) begin failures++; $display("FAIL rst_refill_restall: got %0d expected 9", stalls); end
    checks++; if (n_reads - r0 != 2) begin failures++; $display("FAIL rst_refill_reads: got %0d expected 2", n_reads - r0); end
    checks++; if (rd !== ed) begin failures++; $display("FAIL rst_refill_rdata: got %h expected %h", rd, ed); end
  endtask

  task automatic test_random();
    int stalls, es, er, ew, r0, w0, lat, h0;
    logic [31:0] rd, ed, addr, wd;
    logic we, to;
    h0 = hs_errors;
    for (int i = 0; i < 150; i++) begin
      lat = int'($urandom_range(0, 2));
      ack_lat = lat;
      we = ($urandom_range(0, 9) < 3);
      addr = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 3) |
             ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      wd = $urandom;
      model_access(we, addr, wd, lat, es, ed, er, ew);
      r0 = n_reads; w0 = n_writes;
      do_access(we, addr, wd, stalls, rd, to);
      checks++; if (to || stalls != es) begin failures++; $display("FAIL rnd_stall[%0d] addr %h: got %0d expected %0d", i, addr, stalls, es); end
      checks++; if (n_reads - r0 != er || n_writes - w0 != ew) begin
        failures++; $display("FAIL rnd_memops[%0d]: got r%0d w%0d expected r%0d w%0d", i, n_reads - r0, n_writes - w0, er, ew);
      end
      if (!we) begin
        checks++; if (rd !== ed) begin failures++; $display("FAIL rnd_rdata[%0d] addr %h: got %h expected %h", i, addr, rd, ed); end
      end
    end
    checks++; if (hs_errors != h0) begin failures++; $display("FAIL rnd_handshake: got %0d errors expected 0", hs_errors - h0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ack_delay();
    test_drop_mid_miss();
    test_reset_in_refill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
